// File: rtl/game_pkg.sv
// Shared game types: round state encoding, LFSR seed/taps and default score width.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_WIN,
    S_LOSE,
    S_OVER
  } round_st_t;

  localparam int          SCORE_W_DEF = 11;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  // Taps 16,14,13,11 counted from 1 at the LSB, i.e. bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running seconds prescaler: one-cycle tick each TICKS_PER_SEC enabled cycles.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TICKS_PER_SEC - 1));

  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)     cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: target draw, countdown, lives/level bookkeeping.
// Optional macro ROUND_CONTROLLER_PAUSE_EN adds a pause input that freezes the countdown.
module round_controller
  import game_pkg::*;
#(
  parameter int SCORE_W       = SCORE_W_DEF,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ROUND_TIME    = 30,
  parameter int MIN_TIME      = 10,
  parameter int TARGET_MAX    = 999,
  parameter int LIVES_INIT    = 3,
  parameter int LEVELS_MAX    = 9
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      start_game,
  input  logic signed [SCORE_W-1:0] score,
`ifdef ROUND_CONTROLLER_PAUSE_EN
  input  logic                      pause,
`endif
  output logic [9:0]                target,
  output logic [6:0]                time_left,
  output logic [1:0]                lives,
  output logic [3:0]                level,
  output logic                      score_clear,
  output logic                      round_active,
  output logic                      round_won,
  output logic                      game_over
);

  round_st_t   state, state_nxt;
  logic [15:0] lfsr;
  logic [15:0] score_wide;
  logic        tick, tick_en, win;

  function automatic logic [9:0] draw_target(input logic [9:0] raw);
    int t;
    t = int'(raw) % (TARGET_MAX + 1);
    if (t == 0) t = 1;
    return 10'(t);
  endfunction

  function automatic logic [6:0] round_time(input logic [3:0] lvl);
    int t;
    t = ROUND_TIME - 2 * (int'(lvl) - 1);
    if (t < MIN_TIME) t = MIN_TIME;
    return 7'(t);
  endfunction

`ifdef ROUND_CONTROLLER_PAUSE_EN
  assign tick_en = (state == S_PLAY) && !pause;
`else
  assign tick_en = (state == S_PLAY);
`endif

  sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk    (clk),
    .resetN (resetN),
    .clear  (state == S_LOAD),
    .en     (tick_en),
    .tick   (tick)
  );

  // Sign-extended score against zero-extended target: negatives never match.
  assign score_wide = 16'(score);
  assign win        = (score_wide == {6'd0, target});

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves
  // state_nxt unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_game) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_PLAY;
      S_PLAY: begin
        if (win)                               state_nxt = S_WIN;
        else if (tick && time_left == 7'd1)    state_nxt = S_LOSE;
      end
      S_WIN:   state_nxt = S_LOAD;
      S_LOSE:  state_nxt = (lives == 2'd1) ? S_OVER : S_LOAD;
      S_OVER:  if (start_game) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr      <= LFSR_SEED;
      target    <= '0;
      time_left <= '0;
      lives     <= '0;
      level     <= 4'd1;
    end else begin
      lfsr <= lfsr_next(lfsr);
      case (state)
        S_IDLE, S_OVER: begin
          if (start_game) begin
            lives <= 2'(LIVES_INIT);
            level <= 4'd1;
          end
        end
        S_LOAD: begin
          target    <= draw_target(lfsr[9:0]);
          time_left <= round_time(level);
        end
        S_PLAY:  if (tick && time_left != '0) time_left <= time_left - 7'd1;
        S_WIN:   if (level < 4'(LEVELS_MAX)) level <= level + 4'd1;
        S_LOSE:  lives <= lives - 2'd1;
        default: ;
      endcase
    end
  end

  assign score_clear  = (state == S_LOAD);
  assign round_active = (state == S_PLAY);
  assign round_won    = (state == S_WIN);
  assign game_over    = (state == S_OVER);

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: cycle model checked every clock plus directed literal checks.
module tb_round_controller;

  localparam int SW   = 11;
  localparam int TPS  = 4;
  localparam int RT   = 3;
  localparam int MT   = 1;
  localparam int LI   = 2;
  localparam int TMAX = 999;
  localparam int LMAX = 9;

  logic                 clk = 1'b0;
  logic                 resetN = 1'b0;
  logic                 start_game = 1'b0;
  logic signed [SW-1:0] score = '0;
  logic                 pause = 1'b0;
  logic [9:0]           target;
  logic [6:0]           time_left;
  logic [1:0]           lives;
  logic [3:0]           level;
  logic                 score_clear, round_active, round_won, game_over;

  always #5 clk = ~clk;

  round_controller #(
    .SCORE_W(SW), .TICKS_PER_SEC(TPS), .ROUND_TIME(RT), .MIN_TIME(MT),
    .TARGET_MAX(TMAX), .LIVES_INIT(LI), .LEVELS_MAX(LMAX)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start_game   (start_game),
    .score        (score),
`ifdef ROUND_CONTROLLER_PAUSE_EN
    .pause        (pause),
`endif
    .target       (target),
    .time_left    (time_left),
    .lives        (lives),
    .level        (level),
    .score_clear  (score_clear),
    .round_active (round_active),
    .round_won    (round_won),
    .game_over    (game_over)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOAD, M_PLAY, M_WIN, M_LOSE, M_OVER} mph_t;
  mph_t        m_ph;
  logic [15:0] m_lfsr;
  int          m_target, m_time, m_lives, m_level, m_play_cyc;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int draw(input logic [15:0] v);
    int t;
    t = int'(v[9:0]) % (TMAX + 1);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic int rt_for(input int lvl);
    int t;
    t = RT - 2 * (lvl - 1);
    return (t < MT) ? MT : t;
  endfunction

  function automatic int nonmatch(input int t);
    return (t >= TMAX) ? t - 1 : t + 1;
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_lfsr = 16'hACE1;
    m_target = 0; m_time = 0; m_lives = 0; m_level = 1; m_play_cyc = 0;
  endtask

  task automatic model_step();
    logic [15:0] cur;
    bit          won, ticked;
    cur    = m_lfsr;
    m_lfsr = lfsr_adv(m_lfsr);
    case (m_ph)
      M_IDLE, M_OVER: if (start_game) begin
        m_lives = LI; m_level = 1; m_ph = M_LOAD;
      end
      M_LOAD: begin
        m_target = draw(cur); m_time = rt_for(m_level); m_play_cyc = 0; m_ph = M_PLAY;
      end
      M_PLAY: begin
        won    = (int'(score) == m_target);
        ticked = 1'b0;
        if (!pause) begin
          ticked = ((m_play_cyc % TPS) == TPS - 1);
          m_play_cyc++;
        end
        if (ticked && m_time > 0) m_time--;
        if (won)                       m_ph = M_WIN;
        else if (ticked && m_time == 0) m_ph = M_LOSE;
      end
      M_WIN: begin
        if (m_level < LMAX) m_level++;
        m_ph = M_LOAD;
      end
      M_LOSE: begin
        m_lives--;
        m_ph = (m_lives == 0) ? M_OVER : M_LOAD;
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!resetN) model_reset();
      else         model_step();
      #1;
      check("m_target",       int'(target),       m_target);
      check("m_time_left",    int'(time_left),    m_time);
      check("m_lives",        int'(lives),        m_lives);
      check("m_level",        int'(level),        m_level);
      check("m_score_clear",  int'(score_clear),  int'(m_ph == M_LOAD));
      check("m_round_active", int'(round_active), int'(m_ph == M_PLAY));
      check("m_round_won",    int'(round_won),    int'(m_ph == M_WIN));
      check("m_game_over",    int'(game_over),    int'(m_ph == M_OVER));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_inactive(input int budget, input string name);
    int n;
    n = 0;
    while (round_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(round_active), 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_target", int'(target), 0);
    check("rst_time", int'(time_left), 0);
    check("rst_lives", int'(lives), 0);
    check("rst_level", int'(level), 1);
    check("rst_over", int'(game_over), 0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    start_game = 1'b1; @(negedge clk); start_game = 1'b0;
    check("load_clear", int'(score_clear), 1);
    @(negedge clk);
    check("play_active", int'(round_active), 1);
    check("play_time", int'(time_left), 3);
    check("play_lives", int'(lives), 2);
    check("play_level", int'(level), 1);
    check("target_range", int'(target >= 10'd1 && target <= 10'd999), 1);

    // start_game is ignored mid-round; win on play cycle 4
    score = 11'(nonmatch(m_target)); start_game = 1'b1;
    @(negedge clk); start_game = 1'b0;
    repeat (2) @(negedge clk);
    score = 11'(m_target);
    @(negedge clk);
    check("win_pulse", int'(round_won), 1);
    check("win_lives", int'(lives), 2);
    score = 11'(-5);
    @(negedge clk);
    check("win_level", int'(level), 2);
    check("load2_clear", int'(score_clear), 1);
    @(negedge clk);
    check("lvl2_time", int'(time_left), 1);

    // timeouts until game over
    wait_inactive(10, "timeout1");
    check("lose_time", int'(time_left), 0);
    @(negedge clk);
    check("lose_lives", int'(lives), 1);
    check("lose_level", int'(level), 2);
    @(negedge clk);
    score = 11'(nonmatch(m_target));
    wait_inactive(10, "timeout2");
    @(negedge clk);
    check("over_flag", int'(game_over), 1);
    check("over_lives", int'(lives), 0);
    repeat (3) @(negedge clk);
    check("over_hold", int'(game_over), 1);

    // restart; win on the same cycle as the final tick
    start_game = 1'b1; @(negedge clk); start_game = 1'b0;
    check("restart_lives", int'(lives), 2);
    check("restart_level", int'(level), 1);
    @(negedge clk);
    score = 11'(nonmatch(m_target));
    repeat (10) @(negedge clk);
    check("last_sec", int'(time_left), 1);
    @(negedge clk);
    score = 11'(m_target);
    @(negedge clk);
    check("tie_won", int'(round_won), 1);
    check("tie_lives", int'(lives), 2);
    check("tie_time", int'(time_left), 0);

    // asynchronous reset mid-round
    score = 11'(-1);
    repeat (2) @(negedge clk);
    check("pre_rst_active", int'(round_active), 1);
    repeat (2) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    check("arst_active", int'(round_active), 0);
    check("arst_target", int'(target), 0);
    check("arst_time", int'(time_left), 0);
    check("arst_lives", int'(lives), 0);
    check("arst_level", int'(level), 1);
    check("arst_clear", int'(score_clear), 0);
    @(negedge clk); resetN = 1'b1;
    @(negedge clk);
    start_game = 1'b1; @(negedge clk); start_game = 1'b0;
    check("arst_restart_level", int'(level), 1);
    @(negedge clk);
    check("arst_restart_active", int'(round_active), 1);

`ifdef ROUND_CONTROLLER_PAUSE_EN
    pause = 1'b1;
    score = 11'(nonmatch(m_target));
    repeat (20) @(negedge clk);
    check("pause_time", int'(time_left), 3);
    check("pause_active", int'(round_active), 1);
    score = 11'(m_target);
    @(negedge clk);
    check("pause_win", int'(round_won), 1);
    pause = 1'b0;
    score = '0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
